// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity mode constants and
// the parity helper used by both the TX and RX halves of the controller.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int MAX_DATA_BITS = 9;

  // Narrower words are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side valid/ready word handshake for the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and can be forced back
// to 0 by restart. bit_done marks the last cycle of the current bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done
);

  localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_reg;

  // Free-running period counter, cleared on restart or at the end of a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (restart || (count_reg == LAST)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Decoded from the register only, so the FSM can use it without a loop.
  assign bit_done = (count_reg == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one holding register in front of the shift register so the
// producer can queue the next word while a frame is on the line. All outputs
// come from registers; txd is registered from the next-state decode.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_frame_if.slave bus,
  output logic           txd,
  output logic           busy
);

  generate
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);

  uart_state_t          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] hold_reg, hold_next;
  logic                 hold_full_reg, hold_full_next;
  logic                 ready_reg;
  logic                 parity_reg, parity_next;
  logic [3:0]           bit_idx_reg, bit_idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic                 txd_reg, txd_next;
  logic                 load;
  logic                 accept;
  logic                 restart;
  logic                 bit_done;

  // ready_reg mirrors !hold_full_reg, so an accept can only land in an empty hold.
  assign accept = bus.tx_valid && ready_reg;

  // Counter restarts on every state change and is parked at 0 while idle.
  assign restart = (state_next != state_reg) || (state_reg == ST_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bit_done(bit_done)
  );

  // Next-state, shifter, holding register and next txd level.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    parity_next    = parity_reg;
    bit_idx_next   = bit_idx_reg;
    stop_idx_next  = stop_idx_reg;
    load           = 1'b0;
    txd_next       = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (hold_full_reg) load = 1'b1;
      end
      ST_START: begin
        if (bit_done) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == LAST_BIT) begin
            stop_idx_next = 1'b0;
            state_next    = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          stop_idx_next = 1'b0;
          state_next    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (stop_idx_reg == LAST_STOP) begin
            if (hold_full_reg) load = 1'b1;
            else               state_next = ST_IDLE;
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Moving the held word into the shifter starts a new frame.
    if (load) begin
      shift_next     = hold_reg;
      parity_next    = parity_bit(MAX_DATA_BITS'(hold_reg), PARITY);
      hold_full_next = 1'b0;
      state_next     = ST_START;
    end

    if (accept) begin
      hold_next      = bus.tx_data;
      hold_full_next = 1'b1;
    end

    case (state_next)
      ST_START:  txd_next = 1'b0;
      ST_DATA:   txd_next = shift_next[0];
      ST_PARITY: txd_next = parity_next;
      default:   txd_next = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and drops the held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      ready_reg     <= 1'b1;
      parity_reg    <= 1'b0;
      bit_idx_reg   <= '0;
      stop_idx_reg  <= 1'b0;
      txd_reg       <= 1'b1;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      ready_reg     <= !hold_full_next;
      parity_reg    <= parity_next;
      bit_idx_reg   <= bit_idx_next;
      stop_idx_reg  <= stop_idx_next;
      txd_reg       <= txd_next;
    end
  end

  assign bus.tx_ready = ready_reg;
  assign txd          = txd_reg;
  assign busy         = (state_reg != ST_IDLE) || hold_full_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five DUT configurations (8N1, 8E1, 8O1, 7N2, 9E1)
// at 4 clocks per bit, checked cycle by cycle against a bit-list frame model.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int CPB  = 4;
  localparam int NCFG = 5;

  function automatic int cfg_db(input int i);
    case (i)
      3:       return 7;
      4:       return 9;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_par(input int i);
    case (i)
      1:       return PARITY_EVEN;
      2:       return PARITY_ODD;
      4:       return PARITY_EVEN;
      default: return PARITY_NONE;
    endcase
  endfunction

  function automatic int cfg_sb(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [8:0] tx_data_a  [NCFG];
  logic       tx_valid_a [NCFG];
  logic       tx_ready_a [NCFG];
  logic       txd_a      [NCFG];
  logic       busy_a     [NCFG];

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  generate
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
      localparam int DB = cfg_db(gi);
      uart_tx_frame_if #(.DATA_BITS(DB)) bus ();
      assign bus.tx_data    = tx_data_a[gi][DB-1:0];
      assign bus.tx_valid   = tx_valid_a[gi];
      assign tx_ready_a[gi] = bus.tx_ready;
      uart_tx_frame #(
        .DATA_BITS   (DB),
        .PARITY      (cfg_par(gi)),
        .STOP_BITS   (cfg_sb(gi)),
        .CLKS_PER_BIT(CPB)
      ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .txd  (txd_a[gi]),
        .busy (busy_a[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame model: list of line levels, one entry per bit period.
  function automatic void push_frame(input int idx, input int word);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int b = 0; b < cfg_db(idx); b++) begin
      exp_q.push_back(word[b]);
      ones += word[b];
    end
    if (cfg_par(idx) == PARITY_EVEN) exp_q.push_back((ones % 2) == 1);
    if (cfg_par(idx) == PARITY_ODD)  exp_q.push_back((ones % 2) == 0);
    for (int s = 0; s < cfg_sb(idx); s++) exp_q.push_back(1'b1);
  endfunction

  // Sample ncyc cycles starting with the cycle after the load edge.
  // tx_ready is expected low for sample indices lo..hi.
  task automatic stream(input int idx, input int lo, input int hi, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        tx_valid_a[idx] = 1'b0;
        tx_data_a[idx]  = 9'($urandom);
      end
      check($sformatf("txd c%0d k%0d", idx, k), txd_a[idx], exp_q[k / CPB]);
      check($sformatf("busy c%0d k%0d", idx, k), busy_a[idx], 1);
      check($sformatf("ready c%0d k%0d", idx, k), tx_ready_a[idx], (k >= lo && k <= hi) ? 0 : 1);
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    check($sformatf("%s txd c%0d", tag, idx), txd_a[idx], 1);
    check($sformatf("%s busy c%0d", tag, idx), busy_a[idx], 0);
    check($sformatf("%s ready c%0d", tag, idx), tx_ready_a[idx], 1);
  endtask

  // Offer word at a negedge; it is accepted at the next rising edge (E0).
  task automatic offer(input int idx, input int word);
    @(negedge clk);
    check_idle(idx, "pre");
    tx_data_a[idx]  = 9'(word);
    tx_valid_a[idx] = 1'b1;
    @(negedge clk);
    check($sformatf("held ready c%0d", idx), tx_ready_a[idx], 0);
    check($sformatf("held busy c%0d", idx), busy_a[idx], 1);
    check($sformatf("held txd c%0d", idx), txd_a[idx], 1);
  endtask

  task automatic send_one(input int idx, input int word);
    offer(idx, word);
    tx_valid_a[idx] = 1'b0;
    exp_q.delete();
    push_frame(idx, word);
    stream(idx, 1, 0, exp_q.size() * CPB);
    $display("frame cfg%0d word=%0h bits=%0d", idx, word, exp_q.size());
    @(negedge clk);
    check_idle(idx, "post");
  endtask

  task automatic send_pair(input int idx, input int w1, input int w2);
    int len1;
    offer(idx, w1);
    tx_data_a[idx] = 9'(w2);
    exp_q.delete();
    push_frame(idx, w1);
    len1 = exp_q.size() * CPB;
    push_frame(idx, w2);
    stream(idx, 1, len1 - 1, exp_q.size() * CPB);
    $display("pair cfg%0d words=%0h,%0h cycles=%0d", idx, w1, w2, exp_q.size() * CPB);
    @(negedge clk);
    check_idle(idx, "pair post");
  endtask

  task automatic reset_mid_frame();
    offer(0, 'h00);
    tx_data_a[0] = 9'h0FF;
    exp_q.delete();
    push_frame(0, 'h00);
    // Data bit 3 occupies samples 16..19; reset lands inside it.
    stream(0, 1, 39, 18);
    rst_n = 1'b0;
    #1;
    check_idle(0, "async rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      check($sformatf("after rst txd k%0d", k), txd_a[0], 1);
      check($sformatf("after rst busy k%0d", k), busy_a[0], 0);
    end
    $display("reset mid-frame cfg0 done");
  endtask

  int word;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      tx_data_a[i]  = '0;
      tx_valid_a[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCFG; i++) check_idle(i, "reset");
    rst_n = 1'b1;

    send_one(0, 'hA5);
    send_one(1, 'h07);
    send_one(2, 'h07);
    send_pair(0, 'h55, 'hAA);
    send_one(3, 'h7F);
    send_one(4, 'h1FF);

    for (int i = 0; i < NCFG; i++) begin
      for (int r = 0; r < 4; r++) begin
        word = int'($urandom) & ((1 << cfg_db(i)) - 1);
        send_one(i, word);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      send_pair(i, int'($urandom) & ((1 << cfg_db(i)) - 1),
                   int'($urandom) & ((1 << cfg_db(i)) - 1));
    end

    reset_mid_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
